// File: rtl/cook_timer.sv
// BCD mm:ss cook countdown; one decrement per TICKS_PER_SEC cycles while enabled, expiry pulse on reaching 00:00.
// Optional +30 s quick-add is compiled in with QUICK_ADD_EN.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clearn,
  input  logic        load,
  input  logic [15:0] time_in,
  input  logic        enable,
  input  logic        quick_add,
  output logic [15:0] time_out,
  output logic        timer_done,
  output logic        expired,
  output logic        running
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [1:0]    state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, expired_q, expired_d, running_q;

  function automatic logic [15:0] sanitize(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    mt = (t[15:12] > 4'd9) ? 4'd9 : t[15:12];
    mo = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
    st = (t[7:4]   > 4'd5) ? 4'd5 : t[7:4];
    so = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t == 16'h0000) return t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

`ifdef QUICK_ADD_EN
  // +30 s: seconds tens either absorbs it or wraps by 6 and carries one minute
  function automatic logic [15:0] add30(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (st < 4'd3) return {mt, mo, st + 4'd3, so};
    if (mt == 4'd9 && mo == 4'd9) return 16'h9959;
    st = st - 4'd3;
    if (mo == 4'd9) begin
      mo = 4'd0;
      mt = mt + 4'd1;
    end else begin
      mo = mo + 4'd1;
    end
    return {mt, mo, st, so};
  endfunction
`else
  logic unused_quick_add;
  assign unused_quick_add = quick_add;
`endif

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    pre_d     = pre_q;
    expired_d = 1'b0;
    if (!clearn) begin
      state_d = S_IDLE;
      time_d  = 16'h0000;
      pre_d   = '0;
    end else if (load && state_q != S_RUN) begin
      time_d  = sanitize(time_in);
      pre_d   = '0;
      state_d = (sanitize(time_in) == 16'h0000) ? S_IDLE : S_ARMED;
    end
`ifdef QUICK_ADD_EN
    else if (quick_add && !load && state_q != S_DONE) begin
      // the add replaces this cycle's tick, so the prescaler holds
      time_d  = add30(time_q);
      state_d = (state_q != S_IDLE && enable) ? S_RUN : S_ARMED;
    end
`endif
    else begin
      case (state_q)
        S_ARMED: if (enable) state_d = S_RUN;
        S_RUN: begin
          if (!enable) begin
            state_d = S_ARMED;
          end else if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            time_d = bcd_dec(time_q);
            if (time_d == 16'h0000) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      time_q    <= 16'h0000;
      pre_q     <= '0;
      done_q    <= 1'b1;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pre_q     <= pre_d;
      done_q    <= (time_d == 16'h0000);
      expired_q <= expired_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign time_out   = time_q;
  assign timer_done = done_q;
  assign expired    = expired_q;
  assign running    = running_q;

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- BCD mm:ss countdown timer that sits directly upstream of the magnetron controller logic and drives its timer_done input.
- Holds the cook time loaded from the keypad/entry stage.
- Counts down one second per prescaled tick while the magnetron is on (enable = magnetron latch output).
- Drives the display digits and a one-cycle expiry pulse for the buzzer.

Parameters:
TICKS_PER_SEC, 100, clk cycles per second tick; legal range ≥2.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
clearn  input  1  active-low clear, sampled on clk; same net as the controller's clearn
load  input  1  one-cycle load strobe for time_in
time_in  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
enable  input  1  count permission (magnetron on)
quick_add  input  1  one-cycle +30 s request; functional only with QUICK_ADD_EN
time_out  output  16  current BCD time, same packing as time_in
timer_done  output  1  registered; 1 when count == 00:00
expired  output  1  one-cycle pulse on the RUNNING→DONE transition
running  output  1  1 in RUNNING state

Behaviour:
- Reset (resetn=0 at clk edge) values:
  - state=IDLE, time_out=16'h0000, timer_done=1, expired=0, running=0, prescaler=0.
- Priority per cycle: resetn > clearn > load > quick_add > tick.
- States: IDLE (count 0), ARMED (count ≠0, not counting), RUNNING, DONE.
- Transitions:
  - IDLE –load with nonzero sanitized value→ ARMED.
  - IDLE –load with zero value→ stays IDLE.
  - ARMED –enable=1→ RUNNING; takes effect the following cycle.
  - RUNNING –enable=0→ ARMED (pause): count held, prescaler held, so a partial second resumes.
  - RUNNING –decrement yields 00:00→ DONE; expired=1 for that one cycle only, timer_done=1 from the same edge.
  - DONE → IDLE unconditionally on the next cycle.
- clearn=0 in any state:
  - time_out=0, prescaler=0, state=IDLE, timer_done=1, expired=0.
  - No expired pulse.
- Load:
  - Accepted in IDLE/ARMED/DONE only; ignored in RUNNING.
  - Zeroes the prescaler.
  - Sanitizing: any of min_tens, min_ones, sec_ones >9 → 9; sec_tens >5 → 5.
- Tick:
  - Prescaler increments only in RUNNING.
  - When it equals TICKS_PER_SEC-1 it wraps to 0 and time decrements by one second on that same edge.
  - First decrement therefore comes exactly TICKS_PER_SEC cycles after entering RUNNING from a zero prescaler.
- BCD decrement, borrow chain:
  - sec_ones 0→9 with borrow; sec_tens 0→5 with borrow; min_ones 0→9 with borrow; min_tens decrements.
  - 00:00 is never decremented.
- timer_done:
  - Registered, equals (next count == 0).
  - Zero time after reset or clear therefore holds the controller in reset, so start is refused with no time set.
- enable while IDLE or DONE is ignored.
- running = (state==RUNNING), registered.

Optional Feature:
QUICK_ADD_EN
- Defined:
  - quick_add=1 adds 30 s in BCD, carrying sec→min, in IDLE/ARMED/RUNNING.
  - Saturates at 99:59.
  - From IDLE it moves to ARMED.
  - Prescaler is not disturbed.
  - Ignored in DONE and in any cycle where clearn=0 or load=1.
- Undefined:
  - quick_add is ignored; the port remains for a stable interface.

Test Plan:
- TICKS_PER_SEC=4: reset, load 16'h0002, enable=1 → time_out 0001 after 4 cycles, 0000 after 8; expired high exactly one cycle; timer_done=1; state IDLE next cycle.
- Load 16'h0100, run → after one tick time_out=16'h0059 (borrow); load 16'h1000 → 0959 after one tick.
- Load 0005, run 6 cycles, enable=0 for 10 cycles → time_out frozen at 0004; re-enable → 0003 after 2 more cycles, not 4.
- Load 0030 then load 16'h0045 while RUNNING → value unchanged; clearn=0 mid-run → time_out=0, timer_done=1, expired stays 0.
- Load 16'hAB7C → time_out=16'h9959; load 0000 from IDLE → stays IDLE, timer_done=1.
- With QUICK_ADD_EN: load 0045, quick_add → 0115; load 9945, quick_add → 9959; without macro, quick_add → 0045 unchanged.
